instr_fetch_unit: RTL

- Initiator side of the instruction ROM read port.
- Owns the program counter and drives the word address into the combinational instruction ROM.
- Captures each returned word into a small prefetch FIFO and presents it to decode with a valid/ready handshake.
- Handles redirects from branch/jump resolution and stops fetching at the end of the ROM image.

---
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: drives the instruction ROM address from the PC, buffers fetched words
// in a prefetch FIFO and hands them to decode over a valid/ready handshake.
// Ports: clock, reset_n (async active-low); rom_address/rom_q (combinational ROM);
// redirect_valid/redirect_pc (fetch restart); instr_valid/instr/instr_pc/instr_ready (decode);
// fetch_done (END state). Macro IFETCH_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned ROM_WORDS = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_q,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_done
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] LAST = 32'(ROM_WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {S_RUN, S_STALL, S_END} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [31:0] data_q [DEPTH];
  logic [31:0] addr_q [DEPTH];
  logic pop, push, in_range;
  assign instr_valid = count_q != '0;
  assign pop         = instr_valid && instr_ready;
  assign push        = state_q == S_RUN && (count_q != FULL || pop);
  assign in_range    = redirect_pc < ROM_WORDS;
  assign rom_address = pc_q;
  assign fetch_done  = state_q == S_END;
  // Array contents are not reset, so the head is masked until an entry is valid.
  assign instr       = instr_valid ? data_q[rd_q] : '0;
  assign instr_pc    = instr_valid ? addr_q[rd_q] : '0;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (redirect_valid) begin
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      state_d = in_range ? S_RUN : S_END;
      pc_d    = in_range ? redirect_pc : LAST;
    end else begin
      rd_d    = rd_q + AW'(pop);
      wr_d    = wr_q + AW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
      pc_d    = (push && pc_q != LAST) ? pc_q + 32'd1 : pc_q;
      state_d = (state_q == S_STALL && pop) ? S_RUN :
                (push && pc_q == LAST) ? S_END :
                (state_q == S_RUN && count_d == FULL && !pop) ? S_STALL : state_q;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push && !redirect_valid) begin
      data_q[wr_q] <= rom_q;
      addr_q[wr_q] <= pc_q;
    end
  end
`ifdef IFETCH_PERF_CNT_EN
  // Counters survive redirects; only reset_n clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(push && !redirect_valid);
      perf_stall_cnt <= perf_stall_cnt + 32'(state_q == S_STALL);
    end
  end
`endif
endmodule
